// File: rtl/fft_input_loader_pkg.sv
// Shared definitions for the FFT input loader: sample formats, loader
// state encoding, the fp4 packer result type and the bit-reverse helper.
package fft_pkg;

  localparam logic FMT_FP4 = 1'b0;
  localparam logic FMT_FP8 = 1'b1;

  // Loader states kept as plain constants so older blocks can share them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_FULL  = 2'd3;

  // Result of the fp4 pair packer for one accepted beat.
  typedef struct packed {
    logic        strike;
    logic [15:0] word;
  } fp4_pack_t;

  // Reverse the low 'width' bits of 'value'; bits at and above 'width' are zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                              input int unsigned width);
    logic [31:0] rev;
    rev = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(width)) begin
        rev[i] = value[int'(width) - 1 - i];
      end else begin
        rev[i] = 1'b0;
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample stream, memory write port and frame hand-off of the FFT input loader.
interface fft_input_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  format_mode;
  logic                  in_valid;
  logic                  in_ready;
  logic [15:0]           in_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;
  logic                  wr_format;
  logic                  bank_sel;
  logic                  frame_valid;
  logic                  frame_ack;

  // Loader side.
  modport master (
    input  format_mode, in_valid, in_data, frame_ack,
    output in_ready, wr_en, wr_addr, wr_data, wr_format, bank_sel, frame_valid
  );

  // Producer / memory / consumer side.
  modport slave (
    output format_mode, in_valid, in_data, frame_ack,
    input  in_ready, wr_en, wr_addr, wr_data, wr_format, bank_sel, frame_valid
  );
endinterface

// File: rtl/fft_input_loader_packer.sv
// fp4 pair packer: keeps the even sample's byte and, on the odd sample,
// presents the packed word {even, odd} together with a write strike.
module fp4_pair_packer
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       beat,
  input  logic       odd,
  input  logic [7:0] sample,
  output fp4_pack_t  pack
);

  logic [7:0] held_r;

  // Hold the even sample until its partner arrives, however long that takes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_r <= 8'h00;
    end else if (beat && !odd) begin
      held_r <= sample;
    end else begin
      held_r <= held_r;
    end
  end

  // Packed word and write strike for the current beat.
  always_comb begin
    pack.strike = 1'b0;
    pack.word   = {held_r, sample};
    if (beat && odd) begin
      pack.strike = 1'b1;
    end else begin
      pack.strike = 1'b0;
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// FFT input loader: accepts complex samples, packs them per format, writes
// them bit-reversed into the write bank and hands full frames to the engine.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int N          = 1024,
  parameter int ADDR_WIDTH = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  fft_input_loader_if.master  bus
);

  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(N - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  logic [1:0]            state_r;
  logic [ADDR_WIDTH:0]   sample_cnt_r;
  logic                  fmt_r;
  logic                  in_ready_r;
  logic                  wr_en_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [15:0]           wr_data_r;
  logic                  wr_format_r;
  logic                  bank_sel_r;
  logic                  frame_valid_r;

  logic                  fire_s;
  logic                  beat_fmt_s;
  logic                  last_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic [ADDR_WIDTH-1:0] addr_fp8_s;
  logic [ADDR_WIDTH-1:0] addr_fp4_s;
  logic                  pack_beat_s;
  fp4_pack_t             pack_s;

  // Beat qualification, the beat's format (live on a frame's first beat,
  // latched afterwards) and the bit-reversed target addresses.
  always_comb begin
    fire_s = bus.in_valid & in_ready_r;
    idx_s  = sample_cnt_r[ADDR_WIDTH-1:0];
    last_s = (sample_cnt_r == LAST_IDX);
    if (state_r == ST_IDLE) begin
      beat_fmt_s = bus.format_mode;
    end else begin
      beat_fmt_s = fmt_r;
    end
    addr_fp8_s  = ADDR_WIDTH'(bit_reverse(32'(idx_s), ADDR_WIDTH));
    addr_fp4_s  = {1'b0, (ADDR_WIDTH - 1)'(bit_reverse(32'(idx_s >> 1), ADDR_WIDTH - 1))};
    pack_beat_s = fire_s & (beat_fmt_s == FMT_FP4);
  end

  fp4_pair_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .beat   (pack_beat_s),
    .odd    (idx_s[0]),
    .sample (bus.in_data[7:0]),
    .pack   (pack_s)
  );

  // Memory write port: one registered write per fp8 beat or per fp4 pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= 16'h0000;
      wr_format_r <= FMT_FP4;
    end else begin
      wr_en_r <= 1'b0;
      if (fire_s && (beat_fmt_s == FMT_FP8)) begin
        wr_en_r     <= 1'b1;
        wr_addr_r   <= addr_fp8_s;
        wr_data_r   <= bus.in_data;
        wr_format_r <= FMT_FP8;
      end else if (pack_s.strike) begin
        wr_en_r     <= 1'b1;
        wr_addr_r   <= addr_fp4_s;
        wr_data_r   <= pack_s.word;
        wr_format_r <= FMT_FP4;
      end else begin
        wr_addr_r   <= wr_addr_r;
        wr_data_r   <= wr_data_r;
        wr_format_r <= wr_format_r;
      end
    end
  end

  // Frame sequencing: acceptance window, sample count, hand-off and bank swap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      sample_cnt_r  <= '0;
      fmt_r         <= FMT_FP4;
      in_ready_r    <= 1'b0;
      bank_sel_r    <= 1'b0;
      frame_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          in_ready_r <= 1'b1;
          if (fire_s) begin
            fmt_r        <= bus.format_mode;
            sample_cnt_r <= CNT_ONE;
            state_r      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (fire_s) begin
            sample_cnt_r <= sample_cnt_r + CNT_ONE;
            if (last_s) begin
              in_ready_r <= 1'b0;
              state_r    <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          in_ready_r    <= 1'b0;
          frame_valid_r <= 1'b1;
          state_r       <= ST_FULL;
        end
        ST_FULL: begin
          if (bus.frame_ack && frame_valid_r) begin
            bank_sel_r    <= ~bank_sel_r;
            frame_valid_r <= 1'b0;
            sample_cnt_r  <= '0;
            in_ready_r    <= 1'b1;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          in_ready_r    <= 1'b0;
          frame_valid_r <= 1'b0;
          sample_cnt_r  <= '0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.wr_en       = wr_en_r;
  assign bus.wr_addr     = wr_addr_r;
  assign bus.wr_data     = wr_data_r;
  assign bus.wr_format   = wr_format_r;
  assign bus.bank_sel    = bank_sel_r;
  assign bus.frame_valid = frame_valid_r;

endmodule
